hazard_controller: RTL

Pipeline sequencing controller for the five-stage MIPS core. Sits beside the forwarding unit in ID/EX and resolves the hazards forwarding cannot: load-use stalls, taken-branch flushes, data-memory wait freezes and halt drain. It drives the enable, bubble and flush controls of the PC and pipeline registers, and keeps saturating stall and flush event counters.

---
 rtl/pipe_pkg.sv | 14 +
 rtl/sat_counter.sv | 26 ++
 rtl/hazard_controller.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } hz_state_t;

    localparam logic [4:0] REG_ZERO    = 5'd0;
    localparam int         DRAIN_DEPTH = 3;
    localparam int         DRAIN_W     = 2;

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones; clear wins over increment.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    logic [W-1:0] r_count;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (inc && (r_count != {W{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule

// File: rtl/hazard_controller.sv
// Resolves load-use, taken-branch, memory-wait and halt hazards for the
// five-stage pipeline and counts stall/flush events.
//
// state  | meaning
// RUN    | normal issue; branch, load-use and halt are acted on
// DRAIN  | halt seen; front end held while older instructions retire
// HALTED | pipeline empty and frozen until reset
module hazard_controller
    import pipe_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [4:0]       ra_pipe_id,
    input  logic [4:0]       rb_pipe_id,
    input  logic             uses_ra_id,
    input  logic             uses_rb_id,
    input  logic             halt_pipe_id,
    input  logic             MemToReg_pipe_ex,
    input  logic             RegWrite_pipe_ex,
    input  logic [4:0]       RegWriteDst_pipe_ex,
    input  logic             branch_taken_ex,
    input  logic             dmem_req_mem,
    input  logic             dmem_ready,
    input  logic             cnt_clear,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             halted,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam int                WAIT_W   = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

    hz_state_t          r_state;
    hz_state_t          w_state_nxt;
    logic [DRAIN_W-1:0] r_drain_cnt;
    logic [DRAIN_W-1:0] w_drain_nxt;
    logic [WAIT_W-1:0]  r_wait_cnt;
    logic [WAIT_W-1:0]  w_wait_nxt;
    logic               r_mem_timeout;

    logic w_freeze;
    logic w_ra_hit;
    logic w_rb_hit;
    logic w_load_use;
    logic w_stall_inc;
    logic w_flush_inc;

    assign w_freeze   = dmem_req_mem && !dmem_ready;
    assign w_ra_hit   = uses_ra_id && (ra_pipe_id == RegWriteDst_pipe_ex);
    assign w_rb_hit   = uses_rb_id && (rb_pipe_id == RegWriteDst_pipe_ex);
    assign w_load_use = RegWrite_pipe_ex && MemToReg_pipe_ex &&
                        (RegWriteDst_pipe_ex != REG_ZERO) && (w_ra_hit || w_rb_hit);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= RUN;
            r_drain_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_drain_cnt <= w_drain_nxt;
        end
    end

    // A memory freeze stalls the whole pipe, so the drain count must not advance.
    always_comb begin
        w_state_nxt = r_state;
        w_drain_nxt = r_drain_cnt;
        if (!w_freeze) begin
            case (r_state)
                RUN: begin
                    if (!branch_taken_ex && !w_load_use && halt_pipe_id) begin
                        w_state_nxt = DRAIN;
                        w_drain_nxt = DRAIN_W'(DRAIN_DEPTH);
                    end
                end
                DRAIN: begin
                    if (r_drain_cnt == DRAIN_W'(1)) begin
                        w_state_nxt = HALTED;
                        w_drain_nxt = '0;
                    end else begin
                        w_drain_nxt = r_drain_cnt - 1'b1;
                    end
                end
                HALTED: begin
                    w_state_nxt = HALTED;
                end
                default: begin
                    w_state_nxt = RUN;
                    w_drain_nxt = '0;
                end
            endcase
        end
    end

    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        memwb_en    = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        if ((r_state == HALTED) || w_freeze) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            memwb_en = 1'b0;
        end else if (r_state == DRAIN) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_bubble = 1'b1;
        end else if (branch_taken_ex) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (w_load_use || halt_pipe_id) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_bubble = 1'b1;
        end
    end

    assign halted = (r_state == HALTED);

    always_comb begin
        w_wait_nxt = '0;
        if (w_freeze) begin
            w_wait_nxt = (r_wait_cnt == WAIT_MAX) ? r_wait_cnt : r_wait_cnt + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wait_cnt    <= '0;
            r_mem_timeout <= 1'b0;
        end else begin
            r_wait_cnt    <= w_wait_nxt;
            r_mem_timeout <= r_mem_timeout || (w_wait_nxt == WAIT_MAX);
        end
    end

    assign mem_timeout = r_mem_timeout;

    assign w_stall_inc = !pc_en && (r_state != HALTED);
    assign w_flush_inc = (r_state == RUN) && !w_freeze && branch_taken_ex;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clock   (clock),
        .reset_n (reset_n),
        .inc     (w_stall_inc),
        .clr     (cnt_clear),
        .count   (stall_cycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clock   (clock),
        .reset_n (reset_n),
        .inc     (w_flush_inc),
        .clr     (cnt_clear),
        .count   (flush_count)
    );

endmodule
